// File: rtl/exti_ctrl_if.sv
// Arilla peripheral bus: one-cycle request phase, combinational read data.
interface arilla_bus_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input rdata);
  modport slave  (input req, we, addr, wdata, output rdata);
endinterface

// File: rtl/exti_ctrl.sv
// External-interrupt controller: per-pin sync + glitch filter, edge/level triggers,
// pending/enable registers and a priority-encoded ID word on the arilla bus.
module periph_mem_interface #(
  parameter int BaseAddress = 0,
  parameter int NumWords    = 16,
  parameter int DW          = 32,
  parameter int AW          = 32
) (
  arilla_bus_if.slave                 bus,
  output logic                        hit,
  output logic [NumWords-1:0]         wr_stb,
  output logic [DW-1:0]               wdata,
  input  logic [NumWords-1:0][DW-1:0] rd_words
);
  localparam int            ByteLsb = $clog2(DW / 8);
  localparam int            IdxW    = $clog2(NumWords);
  localparam logic [AW-1:0] Base    = AW'(BaseAddress);
  localparam logic [AW-1:0] Span    = AW'(NumWords * (DW / 8));

  logic [AW-1:0]   offset;
  logic [IdxW-1:0] idx;

  // Addresses below the base wrap to large offsets and so miss.
  assign offset = bus.addr - Base;
  assign idx    = offset[ByteLsb +: IdxW];
  assign hit    = bus.req && (offset < Span);
  assign wdata  = bus.wdata;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_stb = '0;
    if (hit && bus.we) wr_stb[idx] = 1'b1;
  end

  assign bus.rdata = (hit && !bus.we) ? rd_words[idx] : '0;
endmodule

module exti_ctrl #(
  parameter int BaseAddress = 0,
  parameter int NumIO       = 32,
  parameter int SyncStages  = 2,
  parameter int FilterWidth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NumIO-1:0] pins,
  output logic             intr,
  arilla_bus_if.slave      bus_interface,
  output logic             hit
);
  localparam int DW       = $bits(bus_interface.wdata);
  localparam int AW       = $bits(bus_interface.addr);
  localparam int M        = (NumIO + DW - 1) / DW;
  localparam int NumWords = 2 ** $clog2(7 * M + 2);
  localparam int IdW      = $clog2(NumIO + 1);
  localparam int EnW      = 0;
  localparam int ClrW     = M;
  localparam int SetW     = 2 * M;
  localparam int ReW      = 3 * M;
  localparam int FeW      = 4 * M;
  localparam int LvW      = 5 * M;
  localparam int PolW     = 6 * M;
  localparam int FiltW    = 7 * M;
  localparam int IdWord   = 7 * M + 1;

  logic [NumWords-1:0]               wr_stb;
  logic [DW-1:0]                     wdata;
  logic [NumWords-1:0][DW-1:0]       rd_words;
  logic [SyncStages-1:0][NumIO-1:0]  sync_q;
  logic [NumIO-1:0][FilterWidth-1:0] cnt_q;
  logic [NumIO-1:0] f_q, fp_q, enable_q, pending_q, reen_q, feen_q, level_q, pol_q;
  logic [FilterWidth-1:0] thr_q;
  logic [FilterWidth:0]   thr_eff;
  logic [NumIO-1:0] s, evt, wd_rep, clr, set, active;
  logic [IdW-1:0]   id;
  logic             unused_stb;

  periph_mem_interface #(
    .BaseAddress(BaseAddress), .NumWords(NumWords), .DW(DW), .AW(AW)
  ) u_pmi (
    .bus(bus_interface), .hit(hit), .wr_stb(wr_stb), .wdata(wdata), .rd_words(rd_words)
  );

  // Per-bit write mask for a register bank whose first word is `first`.
  function automatic logic [NumIO-1:0] bank_mask(input logic [NumWords-1:0] stb, input int first);
    logic [NumIO-1:0] m;
    for (int i = 0; i < NumIO; i++) m[i] = stb[first + i / DW];
    return m;
  endfunction

  function automatic logic [NumIO-1:0] rw_next(input logic [NumIO-1:0] cur, input logic [NumIO-1:0] wd,
                                               input logic [NumIO-1:0] m);
    return (cur & ~m) | (wd & m);
  endfunction

  // Word w of a register bank, zero above NumIO.
  function automatic logic [DW-1:0] bank_word(input logic [NumIO-1:0] v, input int w);
    logic [DW-1:0] r;
    r = '0;
    for (int b = 0; b < DW; b++)
      if (w * DW + b < NumIO) r[b] = v[w * DW + b];
    return r;
  endfunction

  assign s          = sync_q[SyncStages-1];
  assign thr_eff    = (thr_q == '0) ? (FilterWidth + 1)'(1) : {1'b0, thr_q};
  assign active     = pending_q & enable_q;
  assign intr       = |active;
  assign unused_stb = ^wr_stb;

  always_comb begin
    for (int i = 0; i < NumIO; i++) wd_rep[i] = wdata[i % DW];
    clr = wd_rep & bank_mask(wr_stb, ClrW);
    set = wd_rep & bank_mask(wr_stb, SetW);
    evt = (level_q & (f_q ^ pol_q)) |
          (~level_q & ((f_q & ~fp_q & reen_q) | (~f_q & fp_q & feen_q)));
  end

  // Scanning downwards leaves the lowest active index as the winner.
  always_comb begin
    id = '0;
    for (int i = NumIO - 1; i >= 0; i--)
      if (active[i]) id = IdW'(i + 1);
  end

  always_comb begin
    rd_words = '0;
    for (int w = 0; w < M; w++) begin
      rd_words[EnW + w]  = bank_word(enable_q, w);
      rd_words[ClrW + w] = bank_word(pending_q, w);
      rd_words[SetW + w] = bank_word(pending_q, w);
      rd_words[ReW + w]  = bank_word(reen_q, w);
      rd_words[FeW + w]  = bank_word(feen_q, w);
      rd_words[LvW + w]  = bank_word(level_q, w);
      rd_words[PolW + w] = bank_word(pol_q, w);
    end
    rd_words[FiltW]  = DW'(thr_q);
    rd_words[IdWord] = DW'(id);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the sync chain and filter state are reset too, so a pin already high
      // at reset release is seen as a fresh rise that the cleared REEN ignores.
      sync_q    <= '0;
      cnt_q     <= '0;
      f_q       <= '0;
      fp_q      <= '0;
      enable_q  <= '0;
      pending_q <= '0;
      reen_q    <= '0;
      feen_q    <= '0;
      level_q   <= '0;
      pol_q     <= '0;
      thr_q     <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], pins};
      for (int i = 0; i < NumIO; i++) begin
        if (s[i] == f_q[i]) begin
          cnt_q[i] <= '0;
        end else if ({1'b0, cnt_q[i]} + 1'b1 >= thr_eff) begin
          f_q[i]   <= s[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
      fp_q      <= f_q;
      pending_q <= (pending_q & ~clr) | evt | set;
      enable_q  <= rw_next(enable_q, wd_rep, bank_mask(wr_stb, EnW));
      reen_q    <= rw_next(reen_q, wd_rep, bank_mask(wr_stb, ReW));
      feen_q    <= rw_next(feen_q, wd_rep, bank_mask(wr_stb, FeW));
      level_q   <= rw_next(level_q, wd_rep, bank_mask(wr_stb, LvW));
      pol_q     <= rw_next(pol_q, wd_rep, bank_mask(wr_stb, PolW));
      if (wr_stb[FiltW]) thr_q <= wdata[FilterWidth-1:0];
    end
  end
endmodule

// File: tb/tb_exti_ctrl.sv
// Directed bench for exti_ctrl: NumIO=40 on a 32-bit bus, expected reads
// queued as a scoreboard and compared when the read data is sampled.
module tb_exti_ctrl;
  localparam int NumIO = 40;
  localparam int Base  = 'h100;
  // Word indices for M = 2.
  localparam int EN0 = 0,  EN1 = 1,  CLR0 = 2,  CLR1 = 3,  SET0 = 4,  SET1 = 5;
  localparam int RE0 = 6,  RE1 = 7,  FE0 = 8,   LV0 = 10,  LV1 = 11,  POL1 = 13;
  localparam int FILT = 14, IDW = 15;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [NumIO-1:0] pins  = '0;
  logic             intr;
  logic             hit;

  arilla_bus_if #(.AW(32), .DW(32)) bus ();

  exti_ctrl #(
    .BaseAddress(Base), .NumIO(NumIO), .SyncStages(2), .FilterWidth(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pins(pins), .intr(intr), .bus_interface(bus), .hit(hit)
  );

  always #10 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  function automatic logic [31:0] waddr(input int w);
    return 32'(Base + 4 * w);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Write lands on the next rising edge; returns on the following falling edge.
  task automatic bus_write(input int w, input logic [31:0] data);
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = waddr(w);
    bus.wdata = data;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    bus.we  = 1'b0;
  endtask

  // Combinational read inside the low clock phase; consumes no edge.
  task automatic read_raw(input string tag, input logic [31:0] a, input logic [31:0] exp,
                          input logic exp_hit, input logic chk_hit);
    logic [31:0] data;
    logic        h;
    logic [31:0] e;
    string       t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = a;
    #1;
    data = bus.rdata;
    h    = hit;
    bus.req = 1'b0;
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, data, e);
    if (chk_hit) check({t, "_hit"}, {31'b0, h}, {31'b0, exp_hit});
  endtask

  task automatic rd(input string tag, input int w, input logic [31:0] exp);
    read_raw(tag, waddr(w), exp, 1'b1, 1'b0);
  endtask

  task automatic chk_intr(input string tag, input logic exp);
    check(tag, {31'b0, intr}, {31'b0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    @(negedge clk);
    tick(3);
    rst_n = 1'b1;

    // Reset state
    chk_intr("reset_intr", 1'b0);
    rd("reset_en0", EN0, 32'h0);
    rd("reset_pend0", CLR0, 32'h0);
    rd("reset_filt", FILT, 32'h0);
    rd("reset_id", IDW, 32'h0);

    // 1: rising edge, FILT=0, pending three edges after the capturing edge
    bus_write(RE0, 32'h1);
    bus_write(EN0, 32'h1);
    pins[0] = 1'b1;
    tick(2);
    chk_intr("t1_intr_e1", 1'b0);
    tick(1);
    chk_intr("t1_intr_e2", 1'b0);
    tick(1);
    chk_intr("t1_intr_e3", 1'b1);
    rd("t1_id", IDW, 32'd1);
    rd("t1_pend", CLR0, 32'h1);
    bus_write(CLR0, 32'h1);
    chk_intr("t1_intr_cleared", 1'b0);
    rd("t1_pend_cleared", CLR0, 32'h0);

    // 2: glitch filter, FILT=4, falling edge on pin5
    bus_write(FILT, 32'h4);
    bus_write(FE0, 32'h20);
    pins[5] = 1'b1;
    tick(12);
    rd("t2_rise_no_event", CLR0, 32'h0);
    pins[5] = 1'b0;
    tick(3);
    pins[5] = 1'b1;
    tick(12);
    rd("t2_glitch3", CLR0, 32'h0);
    pins[5] = 1'b0;
    tick(4);
    pins[5] = 1'b1;
    tick(2);
    rd("t2_pulse4_e5", CLR0, 32'h0);
    tick(1);
    rd("t2_pulse4_e6", CLR0, 32'h20);
    chk_intr("t2_intr_disabled", 1'b0);
    bus_write(CLR0, 32'h20);

    // 3: active-low level on pin33
    bus_write(LV1, 32'h2);
    bus_write(POL1, 32'h2);
    bus_write(EN1, 32'h2);
    rd("t3_pend", CLR1, 32'h2);
    rd("t3_id", IDW, 32'd34);
    chk_intr("t3_intr", 1'b1);
    bus_write(CLR1, 32'h2);
    rd("t3_repend", CLR1, 32'h2);
    pins[33] = 1'b1;
    tick(10);
    bus_write(CLR1, 32'h2);
    rd("t3_clr_inactive", CLR1, 32'h0);
    tick(2);
    rd("t3_stays_clear", CLR1, 32'h0);
    chk_intr("t3_intr_off", 1'b0);
    bus_write(LV1, 32'h0);
    bus_write(POL1, 32'h0);
    bus_write(EN1, 32'h0);

    // 4: priority ID and enable gating
    bus_write(SET0, 32'h88);
    bus_write(EN0, 32'h80);
    rd("t4_id8", IDW, 32'd8);
    chk_intr("t4_intr_on", 1'b1);
    bus_write(EN0, 32'h0);
    rd("t4_id0", IDW, 32'd0);
    chk_intr("t4_intr_off", 1'b0);
    rd("t4_pend_clr_view", CLR0, 32'h88);
    rd("t4_pend_set_view", SET0, 32'h88);
    bus_write(CLR0, 32'h88);
    rd("t4_cleared", CLR0, 32'h0);

    // 5: W1C colliding with an edge event, then software set
    bus_write(FILT, 32'h0);
    bus_write(RE0, 32'h4);
    bus_write(SET0, 32'h4);
    pins[2] = 1'b1;
    tick(3);
    bus_write(CLR0, 32'h4);
    rd("t5_event_wins", CLR0, 32'h4);
    bus_write(CLR0, 32'h4);
    rd("t5_plain_clear", CLR0, 32'h0);
    bus_write(SET0, 32'h10);
    rd("t5_sw_set", CLR0, 32'h10);
    bus_write(CLR0, 32'h10);

    // 6: reset mid-count, masked bits, read-only and unmapped words
    bus_write(FILT, 32'h8);
    pins[6] = 1'b1;
    tick(7);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk_intr("t6_reset_intr", 1'b0);
    rd("t6_reset_re0", RE0, 32'h0);
    rd("t6_reset_filt", FILT, 32'h0);
    rd("t6_reset_pend0", CLR0, 32'h0);
    tick(6);
    rd("t6_high_pins_no_event", CLR0, 32'h0);
    rd("t6_pend1", CLR1, 32'h0);
    bus_write(EN1, 32'hFFFF_FFFF);
    rd("t6_en1_mask", EN1, 32'hFF);
    bus_write(SET1, 32'hFFFF_FFFF);
    rd("t6_pend1_mask", CLR1, 32'hFF);
    rd("t6_id33", IDW, 32'd33);
    chk_intr("t6_intr", 1'b1);
    bus_write(IDW, 32'hFFFF_FFFF);
    rd("t6_id_ro", IDW, 32'd33);
    bus_write(CLR1, 32'hFFFF_FFFF);
    bus_write(IDW, 32'h0000_FFFF);
    rd("t6_id_zero", IDW, 32'd0);
    bus_write(LV1, 32'hFFFF_FF00);
    rd("t6_lv1_high_bits", LV1, 32'h0);
    bus_write(RE1, 32'hFFFF_FF00);
    rd("t6_re1_high_bits", RE1, 32'h0);
    read_raw("t6_in_region", waddr(EN1), 32'hFF, 1'b1, 1'b1);
    read_raw("t6_past_region", waddr(16), 32'h0, 1'b0, 1'b1);
    read_raw("t6_below_base", waddr(-1), 32'h0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
